// File: rtl/uart_tx_word_sequencer_if.sv
// Bundle between the requesting logic, the word sequencer and the UART byte transmitter.
// The master side is the requester/transmitter pair; the slave side is the sequencer.
interface uart_tx_word_sequencer_if #(
   parameter int DATA_W = 32
);
   localparam int BYTES = DATA_W / 8;
   localparam int IDX_W = $clog2(BYTES + 1);

   logic              control_tx_i;
   logic [DATA_W-1:0] data_i;
   logic              msb_first_i;
   logic              tx_rdy_i;
   logic              tx_start_o;
   logic [7:0]        tx_byte_o;
   logic [IDX_W-1:0]  byte_idx_o;
   logic              busy_o;
   logic              send_clear_o;
   logic              wr_o;
   logic              err_o;

   modport master (
      output control_tx_i, data_i, msb_first_i, tx_rdy_i,
      input  tx_start_o, tx_byte_o, byte_idx_o, busy_o, send_clear_o, wr_o, err_o
   );

   modport slave (
      input  control_tx_i, data_i, msb_first_i, tx_rdy_i,
      output tx_start_o, tx_byte_o, byte_idx_o, busy_o, send_clear_o, wr_o, err_o
   );
endinterface

// File: rtl/uart_tx_word_sequencer.sv
// Splits a DATA_W-bit word into bytes for a UART byte transmitter, with optional inter-byte gap.
// Define UART_TX_TIMEOUT_EN to add a per-byte tx_rdy_i watchdog that aborts the word with err_o.
module uart_tx_word_sequencer #(
   parameter int DATA_W         = 32,
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 1048575
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   uart_tx_word_sequencer_if.slave   bus
);
   localparam int BYTES = DATA_W / 8;
   localparam int IDX_W = $clog2(BYTES + 1);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

   if ((DATA_W % 8) != 0 || DATA_W < 8 || TIMEOUT_CYCLES < 1) begin : g_paramCheck
      $error("uart_tx_word_sequencer: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES positive");
   end

`ifdef UART_TX_TIMEOUT_EN
   typedef enum logic [2:0] {IDLE, START, WAIT, GAP, DONE, ABORT} state_e;
   localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYCLES - 1);
   logic [TOUT_W-1:0] tout_q, tout_d;
`else
   typedef enum logic [2:0] {IDLE, START, WAIT, GAP, DONE} state_e;
`endif

   state_e            state_q, state_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic              msbFirst_q, msbFirst_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [GAP_W-1:0]  gapCnt_q, gapCnt_d;
   logic [7:0]        txByte_q, txByte_d;
   logic [IDX_W-1:0]  byteIdx_q, byteIdx_d;

   function automatic logic [7:0] pickByte(input logic [DATA_W-1:0] w, input logic msb,
                                           input logic [IDX_W-1:0] i);
      logic [IDX_W-1:0] k;
      k = msb ? (LAST_IDX - i) : i;
      return w[8*int'(k) +: 8];
   endfunction

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= IDLE;
         word_q     <= '0;
         msbFirst_q <= 1'b0;
         idx_q      <= '0;
         gapCnt_q   <= '0;
         txByte_q   <= '0;
         byteIdx_q  <= '0;
`ifdef UART_TX_TIMEOUT_EN
         tout_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         msbFirst_q <= msbFirst_d;
         idx_q      <= idx_d;
         gapCnt_q   <= gapCnt_d;
         txByte_q   <= txByte_d;
         byteIdx_q  <= byteIdx_d;
`ifdef UART_TX_TIMEOUT_EN
         tout_q     <= tout_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      msbFirst_d = msbFirst_q;
      idx_d      = idx_q;
      gapCnt_d   = gapCnt_q;
      txByte_d   = txByte_q;
      byteIdx_d  = byteIdx_q;
`ifdef UART_TX_TIMEOUT_EN
      tout_d     = tout_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.control_tx_i) begin
               word_d     = bus.data_i;
               msbFirst_d = bus.msb_first_i;
               idx_d      = '0;
               state_d    = START;
            end
         end
         START: begin
            state_d = WAIT;
`ifdef UART_TX_TIMEOUT_EN
            tout_d  = '0;
`endif
         end
         WAIT: begin
            // A completed byte wins over a watchdog expiring in the same cycle.
            if (bus.tx_rdy_i) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
                  if (GAP_CYCLES > 0) begin
                     gapCnt_d = GAP_LOAD;
                     state_d  = GAP;
                  end else begin
                     state_d = START;
                  end
               end
            end
`ifdef UART_TX_TIMEOUT_EN
            else if (tout_q == TOUT_LAST) begin
               state_d = ABORT;
            end else begin
               tout_d = tout_q + 1'b1;
            end
`endif
         end
         GAP: begin
            if (gapCnt_q == '0) begin
               state_d = START;
            end else begin
               gapCnt_d = gapCnt_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
`ifdef UART_TX_TIMEOUT_EN
         ABORT:   state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase

      // Byte and index outputs are loaded as START is entered and held until the next START.
      if (state_d == START) begin
         txByte_d  = pickByte(word_d, msbFirst_d, idx_d);
         byteIdx_d = idx_d;
      end
   end

   assign bus.tx_start_o   = (state_q == START);
   assign bus.tx_byte_o    = txByte_q;
   assign bus.byte_idx_o   = byteIdx_q;
   assign bus.busy_o       = (state_q != IDLE);
   assign bus.wr_o         = (state_q == DONE);
`ifdef UART_TX_TIMEOUT_EN
   assign bus.send_clear_o = (state_q == DONE) || (state_q == ABORT);
   assign bus.err_o        = (state_q == ABORT);
`else
   assign bus.send_clear_o = (state_q == DONE);
   assign bus.err_o        = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_word_sequencer.sv
// Bench for uart_tx_word_sequencer: lane 0 runs without a gap, lane 1 with a three-cycle gap.
// Each lane has an automatic byte-transmitter responder and a scoreboard monitor.
module tb_uart_tx_word_sequencer;
   localparam int DW    = 32;
   localparam int IDX_W = 3;

   typedef struct packed {
      logic [7:0]       b;
      logic [IDX_W-1:0] idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int GAP = (g == 0) ? 0 : 3;

      uart_tx_word_sequencer_if #(.DATA_W(DW)) ifc ();

      uart_tx_word_sequencer #(
         .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(20)
      ) dut (
         .clk_i(clk), .reset_i(rst_n), .bus(ifc)
      );

      exp_t       sbq[$];
      int         starts = 0;
      int         dones = 0;
      int         wordBytes = 0;
      int         rdyCyc = -100;
      logic [7:0] lastByte = '0;
      bit         rdyEn = 1'b1;
      bit         abortExpected = 1'b0;

      // Byte transmitter model: answers every start with a tx_rdy_i pulse five cycles later.
      initial begin
         int pending;
         pending = 0;
         ifc.tx_rdy_i = 1'b0;
         forever begin
            @(negedge clk);
            ifc.tx_rdy_i = 1'b0;
            if (!rdyEn) pending = 0;
            if (pending > 0) begin
               pending--;
               if (pending == 0) begin
                  checkOutput($sformatf("lane%0d byte held", g), ifc.tx_byte_o, lastByte);
                  ifc.tx_rdy_i = 1'b1;
                  rdyCyc = cyc;
               end
            end
            if (ifc.tx_start_o && rdyEn) pending = 5;
         end
      end

      // Scoreboard monitor: every start pops one expected byte, every completion closes a word.
      initial begin
         exp_t e;
         forever begin
            @(negedge clk);
            if (ifc.tx_start_o) begin
               starts++;
               checkOutput($sformatf("lane%0d start expected", g), 32'(sbq.size() != 0), 1);
               if (sbq.size() != 0) begin
                  e = sbq.pop_front();
                  wordBytes++;
                  lastByte = ifc.tx_byte_o;
                  checkOutput($sformatf("lane%0d tx_byte", g), ifc.tx_byte_o, e.b);
                  checkOutput($sformatf("lane%0d byte_idx", g), ifc.byte_idx_o, e.idx);
                  if (e.idx != 0)
                     checkOutput($sformatf("lane%0d rdy-to-start", g), cyc - rdyCyc, GAP + 1);
               end
            end
            if (ifc.send_clear_o && !abortExpected) begin
               dones++;
               checkOutput($sformatf("lane%0d wr with clear", g), ifc.wr_o, 1);
               checkOutput($sformatf("lane%0d err at done", g), ifc.err_o, 0);
               checkOutput($sformatf("lane%0d done latency", g), cyc - rdyCyc, 1);
               checkOutput($sformatf("lane%0d bytes per word", g), wordBytes, 4);
               wordBytes = 0;
            end
         end
      end
   end

   task automatic pushWord(input int g, input logic [31:0] d, input bit msb);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         int k;
         k = msb ? 3 - i : i;
         e.b   = d[8*k +: 8];
         e.idx = IDX_W'(i);
         if (g == 0) lane[0].sbq.push_back(e);
         else        lane[1].sbq.push_back(e);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] d, input bit msb, input bit both);
      pushWord(0, d, msb);
      lane[0].ifc.control_tx_i = 1'b1;
      lane[0].ifc.data_i       = d;
      lane[0].ifc.msb_first_i  = msb;
      if (both) begin
         pushWord(1, d, msb);
         lane[1].ifc.control_tx_i = 1'b1;
         lane[1].ifc.data_i       = d;
         lane[1].ifc.msb_first_i  = msb;
      end
      @(negedge clk);
      checkOutput("lane0 start latency", lane[0].ifc.tx_start_o, 1);
      if (both) checkOutput("lane1 start latency", lane[1].ifc.tx_start_o, 1);
      lane[0].ifc.control_tx_i = 1'b0;
      lane[0].ifc.data_i       = ~d;
      lane[0].ifc.msb_first_i  = ~msb;
      lane[1].ifc.control_tx_i = 1'b0;
      lane[1].ifc.data_i       = ~d;
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!lane[0].ifc.busy_o && !lane[1].ifc.busy_o) break;
      end
      checkOutput("return to idle", {lane[1].ifc.busy_o, lane[0].ifc.busy_o}, 0);
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, " tx_start"}, lane[0].ifc.tx_start_o, 0);
      checkOutput({tag, " tx_byte"}, lane[0].ifc.tx_byte_o, 0);
      checkOutput({tag, " byte_idx"}, lane[0].ifc.byte_idx_o, 0);
      checkOutput({tag, " busy"}, lane[0].ifc.busy_o, 0);
      checkOutput({tag, " send_clear"}, lane[0].ifc.send_clear_o, 0);
      checkOutput({tag, " wr"}, lane[0].ifc.wr_o, 0);
      checkOutput({tag, " err"}, lane[0].ifc.err_o, 0);
   endtask

   initial begin
      bit found;
      int donesBefore;
      int s;

      lane[0].ifc.control_tx_i = 1'b0;
      lane[0].ifc.data_i       = '0;
      lane[0].ifc.msb_first_i  = 1'b0;
      lane[1].ifc.control_tx_i = 1'b0;
      lane[1].ifc.data_i       = '0;
      lane[1].ifc.msb_first_i  = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      checkIdleOutputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // LSB-first then MSB-first words on both lanes
      applyStimulus(32'hA1B2C3D4, 1'b0, 1'b1);
      waitIdle();
      applyStimulus(32'hA1B2C3D4, 1'b1, 1'b1);
      waitIdle();

      // Input changes while busy, then control held for a back-to-back word
      pushWord(0, 32'hA1B2C3D4, 1'b0);
      pushWord(0, 32'hFFFFFFFF, 1'b1);
      lane[0].ifc.control_tx_i = 1'b1;
      lane[0].ifc.data_i       = 32'hA1B2C3D4;
      lane[0].ifc.msb_first_i  = 1'b0;
      @(negedge clk);
      checkOutput("mid-word first start", lane[0].ifc.tx_start_o, 1);
      lane[0].ifc.control_tx_i = 1'b0;
      repeat (3) @(negedge clk);
      lane[0].ifc.data_i       = 32'hFFFFFFFF;
      lane[0].ifc.msb_first_i  = 1'b1;
      lane[0].ifc.control_tx_i = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (lane[0].ifc.send_clear_o) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("first word done", 32'(found), 1);
      @(negedge clk);
      checkOutput("idle after done", lane[0].ifc.busy_o, 0);
      @(negedge clk);
      checkOutput("back-to-back start", lane[0].ifc.tx_start_o, 1);
      lane[0].ifc.control_tx_i = 1'b0;
      waitIdle();
      repeat (10) @(negedge clk);
      checkOutput("no extra start", lane[0].starts, 16);

      // Reset during WAIT of byte 2
      pushWord(0, 32'h11223344, 1'b0);
      lane[0].ifc.control_tx_i = 1'b1;
      lane[0].ifc.data_i       = 32'h11223344;
      lane[0].ifc.msb_first_i  = 1'b0;
      @(negedge clk);
      lane[0].ifc.control_tx_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (lane[0].ifc.tx_start_o && lane[0].ifc.byte_idx_o == 2) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("reached byte 2", 32'(found), 1);
      repeat (2) @(negedge clk);
      donesBefore = lane[0].dones;
      lane[0].rdyEn = 1'b0;
      rst_n = 1'b0;
      #1;
      checkIdleOutputs("mid-word reset");
      lane[0].sbq.delete();
      lane[0].wordBytes = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      lane[0].rdyEn = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("no done after reset", lane[0].dones, donesBefore);
      applyStimulus(32'h55667788, 1'b1, 1'b0);
      waitIdle();
      checkOutput("lane0 starts", lane[0].starts, 23);

`ifdef UART_TX_TIMEOUT_EN
      // Watchdog abort with no tx_rdy_i
      lane[0].rdyEn = 1'b0;
      lane[0].abortExpected = 1'b1;
      pushWord(0, 32'hDEADBEEF, 1'b0);
      lane[0].ifc.control_tx_i = 1'b1;
      lane[0].ifc.data_i       = 32'hDEADBEEF;
      @(negedge clk);
      checkOutput("timeout start", lane[0].ifc.tx_start_o, 1);
      s = cyc;
      lane[0].ifc.control_tx_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (lane[0].ifc.send_clear_o) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("timeout seen", 32'(found), 1);
      checkOutput("timeout latency", cyc - s, 21);
      checkOutput("timeout err", lane[0].ifc.err_o, 1);
      checkOutput("timeout wr", lane[0].ifc.wr_o, 0);
      @(negedge clk);
      checkOutput("timeout busy after", lane[0].ifc.busy_o, 0);
      checkOutput("timeout err one cycle", lane[0].ifc.err_o, 0);
      lane[0].sbq.delete();
      lane[0].wordBytes = 0;
      lane[0].abortExpected = 1'b0;
      lane[0].rdyEn = 1'b1;
`else
      s = 0;
`endif

      checkOutput("lane0 dones", lane[0].dones, 5 + s * 0);
      checkOutput("lane1 starts", lane[1].starts, 8);
      checkOutput("lane1 dones", lane[1].dones, 2);
      checkOutput("lane0 scoreboard empty", lane[0].sbq.size(), 0);
      checkOutput("lane1 scoreboard empty", lane[1].sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end
endmodule
